// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state encoding for the RV32-M sequencer
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between the core and the M-op sequencer
interface muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_div_iter.sv
// rtl/muldiv_div_iter.sv - one combinational restoring-division step
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // rem_in < divisor, so the top bit of diff is a clean borrow flag
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign fits    = ~diff[XLEN];

  assign rem_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], fits};
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32-M sequencer: single-cycle multiply, 32-step restoring divide
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam logic [4:0]      LAST_STEP = 5'(DIV_STEPS - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      count;
  logic [2:0]      op_f3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

  // Request decode, evaluated against the live inputs in IDLE
  logic            req_signed;
  logic            req_is_mul;
  logic            req_div_zero;
  logic            req_ovf;
  logic [XLEN-1:0] req_abs_a;
  logic [XLEN-1:0] req_abs_b;
  logic [XLEN-1:0] req_special;

  assign req_signed   = is_signed_div(bus.funct3);
  assign req_is_mul   = ~bus.funct3[2];
  assign req_div_zero = (bus.b == '0);
  assign req_ovf      = req_signed && (bus.a == INT_MIN) && (bus.b == '1);
  assign req_abs_a    = (req_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign req_abs_b    = (req_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
  // funct3[1] separates REM/REMU from DIV/DIVU
  assign req_special  = req_div_zero ? (bus.funct3[1] ? bus.a : '1)
                                     : (bus.funct3[1] ? '0 : bus.a);

  logic            mul_a_sgn;
  logic            mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0] mul_res;

  assign mul_a_sgn = (op_f3 != F3_MULHU);
  assign mul_b_sgn = (op_f3 == F3_MUL) || (op_f3 == F3_MULH);
  assign mul_a_ext = {{XLEN{mul_a_sgn & op_a[XLEN-1]}}, op_a};
  assign mul_b_ext = {{XLEN{mul_b_sgn & op_b[XLEN-1]}}, op_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;
  assign mul_res   = (op_f3 == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  logic [XLEN-1:0] fix_res;

  always_comb begin
    fix_res = quo_q;
    unique case (op_f3)
      F3_DIV:  fix_res = (op_a[XLEN-1] ^ op_b[XLEN-1]) ? -quo_q : quo_q;
      F3_REM:  fix_res = op_a[XLEN-1] ? -rem_q : rem_q;
      F3_REMU: fix_res = rem_q;
      default: fix_res = quo_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      count       <= '0;
      op_f3       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
    end else if (bus.flush) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_f3      <= bus.funct3;
            op_a       <= bus.a;
            op_b       <= bus.b;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (req_is_mul) begin
              state <= ST_MUL;
            end else if (req_div_zero || req_ovf) begin
              result_q    <= req_special;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              rem_q  <= '0;
              quo_q  <= req_abs_a;
              dvsr_q <= req_abs_b;
              count  <= LAST_STEP;
              state  <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_q    <= mul_res;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          count <= count - 5'd1;
          if (count == '0) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q    <= fix_res;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized scoreboard bench for the RV32-M sequencer
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sbv = longint'($signed(b));
    longint          ub = longint'({32'b0, b});
    longint          p;
    longint unsigned pu;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = sa * sbv; return p[31:0]; end
      F3_MULH:   begin p = sa * sbv; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub;  return p[63:32]; end
      F3_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Monitor: every rising out_valid must match the oldest outstanding expectation
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.out_valid && !pv) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("result", bus.result, e.res);
            check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          end
        end
        pv = bus.out_valid;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int acc);
    int w;
    bus.funct3   = f3;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    acc = cyc + 1;
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    else if (push) sb.push_back('{ref_res(f3, a, b), ref_lat(f3, a, b), acc});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!bus.out_valid && w < 100) begin
      if (!bus.busy) check("busy_during_op", {31'b0, bus.busy}, 32'd1);
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int acc;
    issue(f3, a, b, 1'b1, acc);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int          acc;
    int          c0;
    logic [31:0] held;
    logic [2:0]  f3;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.funct3    = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_busy",      {31'b0, bus.busy},      32'd0);
    check("rst_result",    bus.result,             32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(F3_MULH,   32'h8000_0000, 32'h8000_0000);
    run(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(F3_MUL,    32'h0001_2345, 32'hFFFF_FFF0);
    run(F3_DIV,    32'd7,         32'hFFFF_FFFE);
    run(F3_REM,    32'd7,         32'hFFFF_FFFE);
    run(F3_DIVU,   32'h0000_1234, 32'd0);
    run(F3_REMU,   32'h0000_1234, 32'd0);
    run(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    run(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF);
    run(F3_DIVU,   32'hFFFF_FFFF, 32'd1);

    // Backpressure: result frozen in DONE, next op accepted right after release
    bus.out_ready = 1'b0;
    issue(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, acc);
    wait_done();
    held = bus.result;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_result",    bus.result,             held);
      check("bp_in_ready",  {31'b0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    c0 = cyc;
    issue(F3_MUL, 32'd6, 32'd7, 1'b1, acc);
    check("bp_accept_edge", 32'(acc), 32'(c0 + 2));
    wait_done();
    @(negedge clk);

    // Flush during the divide loop
    held = bus.result;
    issue(F3_DIV, 32'd1000, 32'd3, 1'b0, acc);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("flush_busy",      {31'b0, bus.busy},      32'd0);
    check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("flush_result",    bus.result,             held);
    repeat (40) @(negedge clk);
    run(F3_DIVU, 32'd100, 32'd7);

    // Flush in IDLE discards a simultaneous request
    bus.funct3 = F3_DIVU; bus.a = 32'd5; bus.b = 32'd0;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_busy",     {31'b0, bus.busy},     32'd0);
    check("flush_idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'($urandom_range(0, 1000)); rb = ~32'($urandom_range(0, 20)); end
        default: ;
      endcase
      run(f3, ra, rb);
    end

    // Async reset in the middle of a divide
    issue(F3_DIVU, 32'd12345, 32'd7, 1'b0, acc);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_busy",      {31'b0, bus.busy},      32'd0);
    check("arst_result",    bus.result,             32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(F3_REM, 32'hFFFF_FF9C, 32'd7);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
